// File: rtl/data_mem_byte_port.sv
// rtl/data_mem_byte_port.sv - big-endian byte-lane data memory responder for the MIPS MEM stage
//
// Purpose: word-organised RAM that takes load/store requests and handles the
// sub-word and unaligned forms (SB/SH/SW/SWL/SWR, LB/LBU/LH/LHU/LW/LWL/LWR).
// For each accepted request it returns, two cycles later, the merged load data
// and the register byte-write enables.
// Byte offset k = addr[1:0] selects lane 3-k; lane 3 is bits [31:24].
//
// Parameters:
//   ADDR_W      word-address bits (depth = 2**ADDR_W words)
//   INIT_CLEAR  1: zero the RAM after reset before accepting requests
// Optional feature macro: DMEM_ALIGN_TRAP_EN (misaligned accesses trap instead of being forced aligned)
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in RUN)
//   req_write, req_type        store/load flag and access type
//   req_addr                   byte address
//   req_wdata, req_rd_old      store data (unshifted rt) / current rt value for load merging
//   resp_valid, resp_is_load   one-cycle response pulse and its kind
//   resp_rdata, resp_rd_be     merged load result and register byte-write enables
//   resp_err                   misaligned or reserved access (trap build only)
//   init_done                  high once the zero-fill has finished

module data_mem_byte_port #(
  parameter int ADDR_W     = 10,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rd_old,
  output logic        resp_valid,
  output logic        resp_is_load,
  output logic [31:0] resp_rdata,
  output logic [3:0]  resp_rd_be,
  output logic        resp_err,
  output logic        init_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  localparam logic [2:0] T_W   = 3'b000;
  localparam logic [2:0] T_B   = 3'b001;
  localparam logic [2:0] T_BU  = 3'b010;
  localparam logic [2:0] T_H   = 3'b011;
  localparam logic [2:0] T_HU  = 3'b100;
  localparam logic [2:0] T_L   = 3'b101;
  localparam logic [2:0] T_R   = 3'b110;
  localparam logic [2:0] T_RSV = 3'b111;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt;
  logic              clear_we;

  logic [31:0] mem [DEPTH];
  logic [31:0] mem_q;

  logic [1:0]        k, eff_k, st_sh;
  logic [2:0]        eff_type;
  logic [ADDR_W-1:0] idx;
  logic              accept, err, store_we;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic              unused_addr_bits;

  logic        s1_valid, s1_load, s1_err;
  logic [2:0]  s1_type;
  logic [1:0]  s1_k, ld_sh;
  logic [31:0] s1_old;

  logic [31:0] ld_data, ld_shift, merged;
  logic [3:0]  ld_be;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_CLEAR;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      init_done <= (state_next == S_RUN);
      if (state == S_CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    clear_we   = 1'b0;
    case (state)
      S_CLEAR: begin
        clear_we = INIT_CLEAR;
        if (!INIT_CLEAR || cnt == LAST) state_next = S_RUN;
      end
      S_RUN:   state_next = S_RUN;
      default: state_next = S_CLEAR;
    endcase
  end

  assign req_ready = (state == S_RUN);

  // ---------------- request decode ----------------
  assign k                = req_addr[1:0];
  assign idx              = req_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];
  // Gating with reset keeps a request presented during the reset cycle from writing.
  assign accept           = req_valid & req_ready & ~reset;

  always_comb begin
    eff_type = req_type;
    eff_k    = k;
    err      = 1'b0;
`ifdef DMEM_ALIGN_TRAP_EN
    err = (req_type == T_RSV) ||
          (req_type == T_W && k != 2'b00) ||
          ((req_type == T_H || req_type == T_HU) && k[0]);
`else
    // Without trapping, misaligned forms are silently aligned down.
    if (req_type == T_RSV) eff_type = T_W;
    if (eff_type == T_W) eff_k = 2'b00;
    else if (eff_type == T_H || eff_type == T_HU) eff_k = {k[1], 1'b0};
`endif
  end

  always_comb begin
    st_be   = 4'b0000;
    st_data = req_wdata;
    st_sh   = 2'd3 - eff_k;
    case (eff_type)
      T_W: st_be = 4'b1111;
      T_B, T_BU: begin
        st_be   = 4'b1000 >> eff_k;
        st_data = {4{req_wdata[7:0]}};
      end
      T_H, T_HU: begin
        st_be   = eff_k[1] ? 4'b0011 : 4'b1100;
        st_data = {2{req_wdata[15:0]}};
      end
      T_L: begin
        st_be   = 4'b1111 >> eff_k;
        st_data = req_wdata >> {eff_k, 3'b000};
      end
      T_R: begin
        st_be   = 4'b1111 << st_sh;
        st_data = req_wdata << {st_sh, 3'b000};
      end
      default: st_be = 4'b0000;
    endcase
  end

  assign store_we = accept & req_write & ~err;

  // ---------------- RAM (write precedes a later read by one edge) ----------------
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[cnt] <= '0;
    end else if (store_we) begin
      for (int i = 0; i < 4; i++)
        if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
    end
    if (accept) mem_q <= mem[idx];
  end

  // ---------------- stage 1 ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_load  <= 1'b0;
      s1_err   <= 1'b0;
      s1_type  <= T_W;
      s1_k     <= 2'b00;
      s1_old   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_load <= ~req_write;
        s1_err  <= err;
        s1_type <= eff_type;
        s1_k    <= eff_k;
        s1_old  <= req_rd_old;
      end
    end
  end

  // ---------------- load alignment and merge ----------------
  always_comb begin
    ld_be    = 4'b1111;
    ld_data  = mem_q;
    ld_sh    = 2'd3 - s1_k;
    ld_shift = mem_q << {s1_k, 3'b000};
    byte_v   = ld_shift[31:24];
    half_v   = s1_k[1] ? mem_q[15:0] : mem_q[31:16];
    merged   = '0;
    case (s1_type)
      T_B:  ld_data = {{24{byte_v[7]}}, byte_v};
      T_BU: ld_data = {24'h0, byte_v};
      T_H:  ld_data = {{16{half_v[15]}}, half_v};
      T_HU: ld_data = {16'h0, half_v};
      T_L: begin
        ld_data = ld_shift;
        ld_be   = 4'b1111 << s1_k;
      end
      T_R: begin
        ld_data = mem_q >> {ld_sh, 3'b000};
        ld_be   = 4'b1111 >> ld_sh;
      end
      default: ld_data = mem_q;
    endcase
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = ld_be[i] ? ld_data[8*i +: 8] : s1_old[8*i +: 8];
  end

  // ---------------- response register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid   <= 1'b0;
      resp_is_load <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      resp_rd_be   <= 4'b0000;
    end else begin
      resp_valid <= s1_valid;
      if (s1_valid) begin
        resp_is_load <= s1_load;
        resp_err     <= s1_err;
        if (s1_err) begin
          resp_rdata <= s1_old;
          resp_rd_be <= 4'b0000;
        end else if (s1_load) begin
          resp_rdata <= merged;
          resp_rd_be <= ld_be;
        end else begin
          resp_rdata <= '0;
          resp_rd_be <= 4'b0000;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_byte_port.sv
// tb/tb_data_mem_byte_port.sv - directed self-checking bench for data_mem_byte_port
//
// Drives inputs on the falling edge and samples outputs on the falling edge.
// Response vectors are packed as {ok, is_load, err, rd_be, rdata}, where ok means
// the response pulse arrived exactly two cycles after acceptance.
// Honours DMEM_ALIGN_TRAP_EN for the misalignment expectations.

module tb_data_mem_byte_port;

  localparam logic [2:0] W = 3'd0, B = 3'd1, BU = 3'd2, H = 3'd3, HU = 3'd4, L = 3'd5, R = 3'd6, RSV = 3'd7;

  typedef struct packed {
    logic        wr;
    logic [2:0]  ty;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] old;
    logic [38:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_write;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata, req_rd_old;
  logic        req_ready, resp_valid, resp_is_load, resp_err, init_done;
  logic [31:0] resp_rdata;
  logic [3:0]  resp_rd_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_byte_port #(.ADDR_W(4), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd_old(req_rd_old),
    .resp_valid(resp_valid), .resp_is_load(resp_is_load), .resp_rdata(resp_rdata),
    .resp_rd_be(resp_rd_be), .resp_err(resp_err), .init_done(init_done)
  );

  function automatic logic [38:0] st_ok();
    return {1'b1, 1'b0, 1'b0, 4'h0, 32'h0};
  endfunction

  function automatic logic [38:0] ld_ok(logic [3:0] be, logic [31:0] d);
    return {1'b1, 1'b1, 1'b0, be, d};
  endfunction

  function automatic vec_t mk(logic wr, logic [2:0] ty, logic [31:0] addr, logic [31:0] wd,
                              logic [31:0] old, logic [38:0] exp);
    vec_t v;
    v.wr = wr; v.ty = ty; v.addr = addr; v.wd = wd; v.old = old; v.exp = exp;
    return v;
  endfunction

  task automatic idle();
    req_valid = 1'b0; req_write = 1'b0; req_type = W;
    req_addr = '0; req_wdata = '0; req_rd_old = '0;
  endtask

  // Issues one request from a falling edge and returns at the falling edge where the response is due.
  task automatic do_req(input logic wr, input logic [2:0] ty, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] old, output logic [38:0] rsp);
    int n;
    logic early;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_write = wr; req_type = ty;
    req_addr = addr; req_wdata = wd; req_rd_old = old;
    @(negedge clk);
    req_valid = 1'b0;
    early = resp_valid;
    @(negedge clk);
    rsp = {(resp_valid === 1'b1 && early === 1'b0 && n < 200), resp_is_load, resp_err, resp_rd_be, resp_rdata};
  endtask

  task automatic fill_words();
    logic [38:0] rsp;
    for (int i = 0; i < 8; i++)
      do_req(1'b1, W, 32'h20 + 32'(4 * i), 32'h5A000000 + 32'(i), 32'h0, rsp);
  endtask

  task automatic test_reset();
    int n;
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, init_done, resp_valid, resp_is_load, resp_err, resp_rd_be, resp_rdata} !== 41'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b done=%b valid=%b be=%h rdata=%h, want all zero",
               req_ready, init_done, resp_valid, resp_rd_be, resp_rdata);
    end
    reset = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL clear_cycles: got %0d not-ready cycles, want 16", n);
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done: got %b want 1", init_done);
    end
  endtask

  task automatic test_clear_lw();
    logic [38:0] rsp;
    do_req(1'b0, W, 32'h0, 32'h0, 32'hDEADBEEF, rsp);
    checks++;
    if (rsp !== ld_ok(4'hF, 32'h0)) begin
      errors++;
      $display("FAIL clear_lw: got %h want %h", rsp, ld_ok(4'hF, 32'h0));
    end
  endtask

  task automatic test_byte_half();
    vec_t v[$];
    logic [38:0] rsp;
    v.push_back(mk(1'b1, W,  32'h8, 32'h11223344, 32'h0, st_ok()));
    v.push_back(mk(1'b1, B,  32'h9, 32'h123456AA, 32'h0, st_ok()));
    v.push_back(mk(1'b0, W,  32'h8, 32'h0, 32'hDEADBEEF, ld_ok(4'hF, 32'h11AA3344)));
    v.push_back(mk(1'b0, B,  32'h9, 32'h0, 32'hDEADBEEF, ld_ok(4'hF, 32'hFFFFFFAA)));
    v.push_back(mk(1'b0, BU, 32'h9, 32'h0, 32'hDEADBEEF, ld_ok(4'hF, 32'h000000AA)));
    v.push_back(mk(1'b0, B,  32'hB, 32'h0, 32'hDEADBEEF, ld_ok(4'hF, 32'h00000044)));
    v.push_back(mk(1'b1, H,  32'hA, 32'hFFFF8001, 32'h0, st_ok()));
    v.push_back(mk(1'b0, H,  32'hA, 32'h0, 32'hDEADBEEF, ld_ok(4'hF, 32'hFFFF8001)));
    v.push_back(mk(1'b0, HU, 32'hA, 32'h0, 32'hDEADBEEF, ld_ok(4'hF, 32'h00008001)));
    v.push_back(mk(1'b0, H,  32'h8, 32'h0, 32'hDEADBEEF, ld_ok(4'hF, 32'h000011AA)));
    foreach (v[i]) begin
      do_req(v[i].wr, v[i].ty, v[i].addr, v[i].wd, v[i].old, rsp);
      checks++;
      if (rsp !== v[i].exp) begin
        errors++;
        $display("FAIL byte_half[%0d]: got %h want %h", i, rsp, v[i].exp);
      end
    end
  endtask

  task automatic test_lwl_lwr();
    vec_t v[$];
    logic [38:0] rsp;
    v.push_back(mk(1'b1, W, 32'h0, 32'h11223344, 32'h0, st_ok()));
    v.push_back(mk(1'b0, L, 32'h1, 32'h0, 32'hDEADBEEF, ld_ok(4'hE, 32'h223344EF)));
    v.push_back(mk(1'b0, R, 32'h1, 32'h0, 32'hDEADBEEF, ld_ok(4'h3, 32'hDEAD1122)));
    v.push_back(mk(1'b0, L, 32'h0, 32'h0, 32'hDEADBEEF, ld_ok(4'hF, 32'h11223344)));
    v.push_back(mk(1'b0, R, 32'h3, 32'h0, 32'hDEADBEEF, ld_ok(4'hF, 32'h11223344)));
    v.push_back(mk(1'b0, L, 32'h3, 32'h0, 32'hDEADBEEF, ld_ok(4'h8, 32'h44ADBEEF)));
    v.push_back(mk(1'b0, R, 32'h0, 32'h0, 32'hDEADBEEF, ld_ok(4'h1, 32'hDEADBE11)));
    foreach (v[i]) begin
      do_req(v[i].wr, v[i].ty, v[i].addr, v[i].wd, v[i].old, rsp);
      checks++;
      if (rsp !== v[i].exp) begin
        errors++;
        $display("FAIL lwl_lwr[%0d]: got %h want %h", i, rsp, v[i].exp);
      end
    end
  endtask

  task automatic test_swl_swr();
    vec_t v[$];
    logic [38:0] rsp;
    v.push_back(mk(1'b1, W, 32'h10, 32'h11223344, 32'h0, st_ok()));
    v.push_back(mk(1'b1, L, 32'h12, 32'hA1B2C3D4, 32'h0, st_ok()));
    v.push_back(mk(1'b0, W, 32'h10, 32'h0, 32'h0, ld_ok(4'hF, 32'h1122A1B2)));
    v.push_back(mk(1'b1, W, 32'h10, 32'h11223344, 32'h0, st_ok()));
    v.push_back(mk(1'b1, R, 32'h12, 32'hA1B2C3D4, 32'h0, st_ok()));
    v.push_back(mk(1'b0, W, 32'h10, 32'h0, 32'h0, ld_ok(4'hF, 32'hB2C3D444)));
    foreach (v[i]) begin
      do_req(v[i].wr, v[i].ty, v[i].addr, v[i].wd, v[i].old, rsp);
      checks++;
      if (rsp !== v[i].exp) begin
        errors++;
        $display("FAIL swl_swr[%0d]: got %h want %h", i, rsp, v[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    fill_words();
    idle();
    @(negedge clk);
    for (int t = 0; t < 12; t++) begin
      if (t < 8) begin
        req_valid = 1'b1; req_write = 1'b0; req_type = W;
        req_addr = 32'h20 + 32'(4 * t); req_rd_old = 32'h0;
        checks++;
        if (req_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready[%0d]: got %b want 1", t, req_ready);
        end
      end else begin
        req_valid = 1'b0;
      end
      checks++;
      if (t >= 2 && t < 10) begin
        exp = 32'h5A000000 + 32'(t - 2);
        if ({resp_valid, resp_rdata} !== {1'b1, exp}) begin
          errors++;
          $display("FAIL b2b_resp[%0d]: got valid=%b data=%h want valid=1 data=%h", t, resp_valid, resp_rdata, exp);
        end
      end else if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle[%0d]: got valid=%b want 0", t, resp_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store_then_load();
    idle();
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      req_valid = (t < 2);
      req_write = (t == 0);
      req_type = W; req_addr = 32'h24; req_wdata = 32'hCAFEF00D; req_rd_old = 32'h0;
      if (t == 2) begin
        checks++;
        if ({resp_valid, resp_is_load} !== 2'b10) begin
          errors++;
          $display("FAIL stld_store: got valid=%b load=%b want 1 0", resp_valid, resp_is_load);
        end
      end
      if (t == 3) begin
        checks++;
        if ({resp_valid, resp_is_load, resp_rd_be, resp_rdata} !== {1'b1, 1'b1, 4'hF, 32'hCAFEF00D}) begin
          errors++;
          $display("FAIL stld_load: got valid=%b be=%h data=%h want 1 f cafef00d", resp_valid, resp_rd_be, resp_rdata);
        end
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_misaligned();
    vec_t v[$];
    logic [38:0] rsp;
    v.push_back(mk(1'b1, W, 32'h0, 32'h55667788, 32'h0, st_ok()));
`ifdef DMEM_ALIGN_TRAP_EN
    v.push_back(mk(1'b1, W,   32'h2, 32'h99AABBCC, 32'h0, {1'b1, 1'b0, 1'b1, 4'h0, 32'h0}));
    v.push_back(mk(1'b0, W,   32'h0, 32'h0, 32'h0, ld_ok(4'hF, 32'h55667788)));
    v.push_back(mk(1'b0, H,   32'h1, 32'h0, 32'h12345678, {1'b1, 1'b1, 1'b1, 4'h0, 32'h12345678}));
    v.push_back(mk(1'b0, RSV, 32'h3, 32'h0, 32'hCAFEBABE, {1'b1, 1'b1, 1'b1, 4'h0, 32'hCAFEBABE}));
`else
    v.push_back(mk(1'b1, W,   32'h2, 32'h99AABBCC, 32'h0, st_ok()));
    v.push_back(mk(1'b0, W,   32'h0, 32'h0, 32'h0, ld_ok(4'hF, 32'h99AABBCC)));
    v.push_back(mk(1'b0, H,   32'h1, 32'h0, 32'h12345678, ld_ok(4'hF, 32'hFFFF99AA)));
    v.push_back(mk(1'b0, RSV, 32'h3, 32'h0, 32'hCAFEBABE, ld_ok(4'hF, 32'h99AABBCC)));
`endif
    foreach (v[i]) begin
      do_req(v[i].wr, v[i].ty, v[i].addr, v[i].wd, v[i].old, rsp);
      checks++;
      if (rsp !== v[i].exp) begin
        errors++;
        $display("FAIL misaligned[%0d]: got %h want %h", i, rsp, v[i].exp);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int n, pulses;
    logic [38:0] rsp;
    fill_words();
    idle();
    @(negedge clk);
    for (int t = 0; t < 6; t++) begin
      if (t < 5) begin
        req_valid = 1'b1; req_write = 1'b0; req_type = W; req_addr = 32'h20 + 32'(4 * t);
      end else begin
        req_valid = 1'b0;
        reset = 1'b1;
      end
      if (t >= 2) begin
        checks++;
        if ({resp_valid, resp_rdata} !== {1'b1, 32'h5A000000 + 32'(t - 2)}) begin
          errors++;
          $display("FAIL inflight_pre[%0d]: got valid=%b data=%h", t, resp_valid, resp_rdata);
        end
      end
      @(negedge clk);
    end
    reset = 1'b0;
    n = 0;
    pulses = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      if (resp_valid !== 1'b0) pulses++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL inflight_dropped: got %0d response pulses after reset, want 0", pulses);
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL inflight_clear_cycles: got %0d want 16", n);
    end
    do_req(1'b0, W, 32'h20, 32'h0, 32'h0, rsp);
    checks++;
    if (rsp !== ld_ok(4'hF, 32'h0)) begin
      errors++;
      $display("FAIL reclear_lw: got %h want %h", rsp, ld_ok(4'hF, 32'h0));
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_clear_lw();
    test_byte_half();
    test_lwl_lwr();
    test_swl_swr();
    test_back_to_back();
    test_store_then_load();
    test_misaligned();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
